// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB plus 2-bit bimodal branch predictor with EX-stage resolution
module branch_predictor #(
    parameter int         ENTRIES   = 16,
    parameter int         PRED_MODE = 1,
    parameter logic [1:0] CTR_ALLOC = 2'b10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_ex_vld,
    input  logic        i_ex_is_br,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_mispred,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int TAG_W = 30 - IDX_W;
    localparam bit DYN   = (PRED_MODE == 1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             ex_br;
    logic             unused_pc_bits;

    assign if_idx         = i_if_pc[IDX_W+1:2];
    assign if_tag         = i_if_pc[31:IDX_W+2];
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_idx         = i_ex_pc[IDX_W+1:2];
    assign ex_tag         = i_ex_pc[31:IDX_W+2];
    assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_br          = i_ex_vld && i_ex_is_br;
    assign unused_pc_bits = ^i_if_pc[1:0];

    always_comb begin
        o_pred_taken  = 1'b0;
        o_pred_target = 32'h0;
        if (DYN) begin
            o_pred_taken  = if_hit && ctr_q[if_idx][1];
            o_pred_target = tgt_q[if_idx];
        end
    end

    always_comb begin
        o_mispred = 1'b0;
        if (i_ex_vld) begin
            if (i_ex_is_br)
                o_mispred = (i_ex_pred_taken != i_ex_taken) ||
                            (i_ex_taken && (i_ex_pred_target != i_ex_target));
            else
                o_mispred = i_ex_pred_taken;
        end
        o_redirect_pc = (i_ex_taken && i_ex_is_br) ? i_ex_target : i_ex_pc + 32'd4;
    end

    // Table write: training on resolved branches, invalidation on alias hits.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (DYN) begin
            if (ex_br) begin
                if (ex_hit) begin
                    if (i_ex_taken) begin
                        ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
                        tgt_q[ex_idx] <= i_ex_target;
                    end else begin
                        ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
                    end
                end else if (i_ex_taken) begin
                    valid_q[ex_idx] <= 1'b1;
                    tag_q[ex_idx]   <= ex_tag;
                    tgt_q[ex_idx]   <= i_ex_target;
                    ctr_q[ex_idx]   <= CTR_ALLOC;
                end
            end else if (i_ex_vld && i_ex_pred_taken && ex_hit) begin
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_br_cnt      <= 32'h0;
            o_mispred_cnt <= 32'h0;
        end else begin
            if (ex_br)
                o_br_cnt <= o_br_cnt + 32'd1;
            if (o_mispred)
                o_mispred_cnt <= o_mispred_cnt + 32'd1;
        end
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline.
- Replaces the fixed predict-not-taken path, which has branch resolution in EX and a hardwired mispredict flag.
- IF side: combinational BTB + 2-bit bimodal lookup on the fetch PC gives the predicted next PC.
- EX side: resolved branch/jump outcomes train the tables, and the block produces the mispredict flag plus redirect PC used to flush IF_ID/ID_EX.

Parameters:
ENTRIES, 16, number of BTB/BHT entries; power of two, 2..256.
PRED_MODE, 1, 0 = static not-taken (tables ignored, o_pred_taken=0); 1 = bimodal 2-bit counters with BTB.
CTR_ALLOC, 2'b10, counter value written when a taken branch allocates a new entry.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_if_pc  in  32  fetch PC (IF stage)
o_pred_taken  out  1  IF prediction: redirect fetch
o_pred_target  out  32  predicted target (valid when o_pred_taken)
i_ex_vld  in  1  EX holds a real instruction (0 for bubble/flushed slot)
i_ex_is_br  in  1  EX instruction is B-type, JAL or JALR
i_ex_pc  in  32  PC of EX instruction
i_ex_taken  in  1  resolved outcome (1 for JAL/JALR)
i_ex_target  in  32  resolved target (ALU result)
i_ex_pred_taken  in  1  prediction carried down the pipe with the instruction
i_ex_pred_target  in  32  predicted target carried down the pipe
o_mispred  out  1  flush IF_ID and ID_EX, load o_redirect_pc
o_redirect_pc  out  32  correct next PC
o_br_cnt  out  32  resolved branch/jump count
o_mispred_cnt  out  32  mispredict count

Behaviour:
- Index and tag:
  - IDX_W = log2(ENTRIES).
  - index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
  - Each entry holds: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational, same cycle as i_if_pc):
  - hit = valid[idx] & (tag == stored tag).
  - Mode 1: o_pred_taken = hit & ctr[1]; o_pred_target = stored target.
  - Mode 0: o_pred_taken = 0, o_pred_target = 0.
- Resolution (combinational, EX):
  - If i_ex_vld & i_ex_is_br: wrong = (i_ex_pred_taken != i_ex_taken) | (i_ex_taken & i_ex_pred_target != i_ex_target).
  - If i_ex_vld & !i_ex_is_br: wrong = i_ex_pred_taken (alias hit on a non-branch).
  - If !i_ex_vld: o_mispred = 0.
  - o_redirect_pc = i_ex_taken&i_ex_is_br ? i_ex_target : i_ex_pc+4 (32-bit wrap).
- Update (posedge, only when i_ex_vld & i_ex_is_br & PRED_MODE==1):
  - Hit, taken: ctr = min(ctr+1, 3); target <= i_ex_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate/overwrite entry: valid=1, tag, target, ctr=CTR_ALLOC.
  - Miss, not taken: no write.
  - Non-branch predicted taken (alias): invalidate that entry if tag matches.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents; the write is visible from the next cycle.
- Counters:
  - o_br_cnt increments on each i_ex_vld & i_ex_is_br.
  - o_mispred_cnt increments on each o_mispred.
  - Both wrap at 2^32 and count in both modes.
- Reset (i_rst_n=0 at posedge):
  - All valid bits cleared, ctr cleared to 2'b01, both counters cleared.
  - Combinational outputs follow: o_pred_taken=0, o_pred_target=0 for all PCs.
  - Reset overrides a simultaneous update.
  - Reset mid-operation discards any pending training; no partial entry remains.
- Single write port, one update per cycle.
- Tables must be flop-based so they can be cleared by synchronous reset.

Test Plan:
1. Reset, then lookup pc=0x100 -> o_pred_taken=0, o_pred_target=0; counters=0.
2. EX beq pc=0x100 taken to 0x80, pred 0 -> o_mispred=1, o_redirect_pc=0x80; next cycle lookup 0x100 -> taken, target 0x80, ctr=2.
3. Same branch resolved not-taken twice -> ctr 2->1->0, o_pred_taken=0 after the first; o_redirect_pc=0x104, o_mispred=1 on the first only.
4. ENTRIES=16: pc 0x100 and 0x140 share index 0 with different tags -> 0x140 misses; taken 0x140 to 0x200 replaces the entry; 0x100 then misses.
5. JALR pc=0x20 taken, predicted target 0x40, actual 0x44 -> o_mispred=1, redirect 0x44, stored target becomes 0x44.
6. PRED_MODE=0: 10 taken branches -> o_pred_taken always 0, o_br_cnt=10, o_mispred_cnt=10; assert reset during an update cycle -> entry not written, counters 0.
